cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control unit for the 8-bit accumulator CPU.
- Sequences fetch, decode and execute by driving enables for the IR, PC, MAR, memory, accumulator and busC source mux.
- Consumes the 5-bit opcode from the instruction register and the ALU zero flag.
- Handles variable-latency memory via a req/ready handshake with timeout.

Parameters:
- OPCODE_W, 5, opcode width from IR.
- TIMEOUT, 15, max cycles to wait for mem_ready before bus error; 0 = wait forever.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  leave IDLE and begin fetching.
- opcode  in  OPCODE_W  current IR opcode (IR[7:3]).
- zero  in  1  accumulator-zero flag.
- mem_ready  in  1  memory completes current rd/wr this cycle.
- ir_ena  out  1  IR load enable.
- ir_sel  out  1  IR mux select (0 = busC, 1 = clear to zero).
- pc_inc  out  1  PC += 1.
- pc_load  out  1  PC <= busC.
- mar_ena  out  1  MAR <= busC.
- bus_sel  out  2  busC source: 00 none, 01 PC, 10 MEM, 11 ACC.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- acc_ena  out  1  ACC <= ALU result.
- alu_op  out  2  00 pass, 01 add, 10 sub.
- instr_done  out  1  one-cycle pulse on instruction retire.
- illegal  out  1  one-cycle pulse on undefined opcode.
- halted  out  1  high in HALT.
- bus_err  out  1  high in ERR (sticky until reset).

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; wait counter 0. Reset mid-operation aborts immediately, with no partial strobes.
- Opcodes:
  - 00000 NOP
  - 00001 LDA
  - 00010 STA
  - 00011 ADD
  - 00100 SUB
  - 00101 JMP
  - 00110 JZ
  - 11111 HLT
  - all others illegal
- Instruction format:
  - Byte 0 = opcode + 3 ignored bits.
  - LDA/STA/ADD/SUB/JMP/JZ carry a second byte holding an address.
- Outputs are combinational from state, opcode, zero and mem_ready. Every strobe lasts exactly one cycle unless stated otherwise.
- IDLE: all strobes 0. start=1 -> F0.
- F0: bus_sel=01, mar_ena=1 -> F1.
- F1: mem_rd=1, bus_sel=10 held while waiting.
  - On mem_ready: ir_ena=1, ir_sel=0, pc_inc=1 -> DEC.
- DEC:
  - NOP: instr_done=1 -> F0.
  - HLT: instr_done=1 -> HALT.
  - JZ with zero=0: pc_inc=1 (skip operand), instr_done=1 -> F0.
  - Illegal: ir_ena=1, ir_sel=1 (clear IR), illegal=1 -> F0. No instr_done.
  - Otherwise -> O0.
- O0: bus_sel=01, mar_ena=1 -> O1.
- O1: mem_rd=1, bus_sel=10 while waiting.
  - JMP/JZ, on mem_ready: pc_load=1, pc_inc=0 (load wins), instr_done=1 -> F0.
  - LDA/STA/ADD/SUB, on mem_ready: pc_inc=1, mar_ena=1 -> EX.
- EX:
  - LDA/ADD/SUB: mem_rd=1, bus_sel=10, alu_op=00/01/10. On mem_ready: acc_ena=1, instr_done=1 -> F0.
  - STA: mem_wr=1, bus_sel=11. On mem_ready: instr_done=1 -> F0.
- HALT: halted=1, all strobes 0. Exit only by reset; start ignored.
- ERR: bus_err=1, all strobes 0. Exit only by reset.
- Latency with zero-wait memory (mem_ready high in first request cycle):
  - NOP/HLT: 3 cycles.
  - JMP/JZ-taken: 5 cycles.
  - JZ-not-taken: 3 cycles.
  - LDA/STA/ADD/SUB: 6 cycles.
- Wait counter:
  - Cleared on entry to any request state (F1, O1, EX).
  - Increments each cycle mem_ready=0 in that state.
  - Reaching TIMEOUT with mem_ready still 0 -> ERR next cycle; strobes dropped.
  - mem_ready in the same cycle the counter hits TIMEOUT counts as success.
- Opcode is sampled only in DEC and later; opcode changes during F0/F1 are don't-care.
- mem_rd and mem_wr are never high together. pc_inc and pc_load are never high together.

Test Plan:
1. Reset low mid-EX of ADD with mem_rd=1 -> all outputs 0 asynchronously; after release, state IDLE, no strobes until start.
2. start, zero-wait memory, opcode=00011 (ADD) -> mar_ena, mem_rd+ir_ena+pc_inc, DEC, mar_ena, mem_rd+pc_inc+mar_ena, then mem_rd+acc_ena+alu_op=01+instr_done; 6 cycles, back to F0.
3. JZ with zero=0 -> DEC asserts pc_inc+instr_done, 3 cycles total. JZ with zero=1 -> O1 asserts pc_load=1 with pc_inc=0.
4. opcode=01010 (illegal) -> DEC asserts ir_ena=1, ir_sel=1, illegal=1 for one cycle, no instr_done, next state F0.
5. STA with mem_ready delayed 4 cycles in EX -> mem_wr and bus_sel=11 held 5 cycles, instr_done on 5th. With TIMEOUT=3 and mem_ready never asserted -> bus_err=1 sticky, strobes 0.
6. HLT -> halted=1 after DEC; start pulses ignored; rst=0 returns to IDLE with halted=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle control unit for the 8-bit accumulator CPU. Walks each
//   instruction through fetch (F0/F1), decode (DEC), operand fetch (O0/O1)
//   and execute (EX), driving the datapath enables combinationally from the
//   current state, opcode, zero flag and mem_ready.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   start           leave IDLE and begin fetching
//   opcode          IR[7:3], only looked at from DEC onward
//   zero            accumulator-zero flag (used by JZ in DEC)
//   mem_ready       memory completes the current rd/wr this cycle
//   ir_ena, ir_sel  IR load enable / IR source (0 busC, 1 clear)
//   pc_inc, pc_load PC increment / PC <= busC
//   mar_ena         MAR <= busC
//   bus_sel         busC source: 00 none, 01 PC, 10 MEM, 11 ACC
//   mem_rd, mem_wr  memory request strobes
//   acc_ena, alu_op ACC <= ALU result, ALU op (00 pass, 01 add, 10 sub)
//   instr_done      one-cycle pulse on instruction retire
//   illegal         one-cycle pulse on an undefined opcode
//   halted, bus_err level outputs for HALT / ERR states
//   dbg_state       current FSM state, for observation only
//
// Memory handshake: in a request state (F1, O1, EX) mem_rd or mem_wr is held
// high together with the matching bus_sel until the cycle in which mem_ready
// is high; that cycle completes the transfer and the FSM moves on. A wait
// counter, cleared on entry to each request state, counts cycles spent with
// mem_ready low. If the counter already equals TIMEOUT and mem_ready is still
// low, the FSM goes to ERR on the next edge. mem_ready arriving in that same
// cycle still succeeds. TIMEOUT = 0 disables the timeout.

module cpu_sequencer #(
  parameter int OPCODE_W = 5,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                ir_ena,
  output logic                ir_sel,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_ena,
  output logic [1:0]          bus_sel,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                acc_ena,
  output logic [1:0]          alu_op,
  output logic                instr_done,
  output logic                illegal,
  output logic                halted,
  output logic                bus_err,
  output logic [3:0]          dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_DEC  = 4'd3,
    S_O0   = 4'd4,
    S_O1   = 4'd5,
    S_EX   = 4'd6,
    S_HALT = 4'd7,
    S_ERR  = 4'd8
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_HLT = {OPCODE_W{1'b1}};

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_PC   = 2'b01;
  localparam logic [1:0] BUS_MEM  = 2'b10;
  localparam logic [1:0] BUS_ACC  = 2'b11;

  localparam int             CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out;
  logic             is_jump;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only meaningful inside a request state with mem_ready low.
  assign timed_out = (TIMEOUT != 0) && (cnt_q == TMO);
  assign is_jump   = (opcode == OP_JMP) || (opcode == OP_JZ);
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ir_ena     = 1'b0;
    ir_sel     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_ena    = 1'b0;
    bus_sel    = BUS_NONE;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    acc_ena    = 1'b0;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    bus_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_F0;
      end

      S_F0: begin
        bus_sel = BUS_PC;
        mar_ena = 1'b1;
        cnt_d   = '0;
        state_d = S_F1;
      end

      S_F1: begin
        mem_rd  = 1'b1;
        bus_sel = BUS_MEM;
        if (mem_ready) begin
          ir_ena  = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DEC;
        end else if (timed_out) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DEC: begin
        case (opcode)
          OP_NOP: begin
            instr_done = 1'b1;
            state_d    = S_F0;
          end
          OP_HLT: begin
            instr_done = 1'b1;
            state_d    = S_HALT;
          end
          OP_JZ: begin
            if (!zero) begin
              // Branch not taken: step PC over the address byte.
              pc_inc     = 1'b1;
              instr_done = 1'b1;
              state_d    = S_F0;
            end else begin
              state_d = S_O0;
            end
          end
          OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_JMP: begin
            state_d = S_O0;
          end
          default: begin
            ir_ena  = 1'b1;
            ir_sel  = 1'b1;
            illegal = 1'b1;
            state_d = S_F0;
          end
        endcase
      end

      S_O0: begin
        bus_sel = BUS_PC;
        mar_ena = 1'b1;
        cnt_d   = '0;
        state_d = S_O1;
      end

      S_O1: begin
        mem_rd  = 1'b1;
        bus_sel = BUS_MEM;
        if (mem_ready) begin
          if (is_jump) begin
            // Address byte goes straight into PC; no increment alongside.
            pc_load    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_F0;
          end else begin
            // Address byte lands in MAR for the data access in EX.
            pc_inc  = 1'b1;
            mar_ena = 1'b1;
            cnt_d   = '0;
            state_d = S_EX;
          end
        end else if (timed_out) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_EX: begin
        if (opcode == OP_STA) begin
          mem_wr  = 1'b1;
          bus_sel = BUS_ACC;
        end else begin
          mem_rd  = 1'b1;
          bus_sel = BUS_MEM;
          if (opcode == OP_ADD)      alu_op = 2'b01;
          else if (opcode == OP_SUB) alu_op = 2'b10;
          else                       alu_op = 2'b00;
        end
        if (mem_ready) begin
          acc_ena    = (opcode != OP_STA);
          instr_done = 1'b1;
          state_d    = S_F0;
        end else if (timed_out) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      S_ERR: begin
        bus_err = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a table of per-cycle input/expected-output records
// run through a scoreboard, followed by hand-written reset and timeout
// sequences.

module tb_cpu_sequencer;

  localparam int TMO = 15;

  // Output vector layout:
  // {ir_ena, ir_sel, pc_inc, pc_load, mar_ena, bus_sel[1:0], mem_rd, mem_wr,
  //  acc_ena, alu_op[1:0], instr_done, illegal, halted, bus_err}
  localparam logic [15:0] IRE     = 16'h8000;
  localparam logic [15:0] IRS     = 16'h4000;
  localparam logic [15:0] PCI     = 16'h2000;
  localparam logic [15:0] PCL     = 16'h1000;
  localparam logic [15:0] MAR     = 16'h0800;
  localparam logic [15:0] BS_PC   = 16'h0200;
  localparam logic [15:0] BS_MEM  = 16'h0400;
  localparam logic [15:0] BS_ACC  = 16'h0600;
  localparam logic [15:0] RD      = 16'h0100;
  localparam logic [15:0] WR      = 16'h0080;
  localparam logic [15:0] ACC     = 16'h0040;
  localparam logic [15:0] ALU_ADD = 16'h0010;
  localparam logic [15:0] ALU_SUB = 16'h0020;
  localparam logic [15:0] DONE    = 16'h0008;
  localparam logic [15:0] ILL     = 16'h0004;
  localparam logic [15:0] HLT_O   = 16'h0002;
  localparam logic [15:0] ERR_O   = 16'h0001;

  localparam logic [4:0] NOP = 5'b00000;
  localparam logic [4:0] LDA = 5'b00001;
  localparam logic [4:0] STA = 5'b00010;
  localparam logic [4:0] ADD = 5'b00011;
  localparam logic [4:0] SUB = 5'b00100;
  localparam logic [4:0] JMP = 5'b00101;
  localparam logic [4:0] JZ  = 5'b00110;
  localparam logic [4:0] HLT = 5'b11111;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [4:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_ena, ir_sel, pc_inc, pc_load, mar_ena;
  logic [1:0] bus_sel;
  logic       mem_rd, mem_wr, acc_ena;
  logic [1:0] alu_op;
  logic       instr_done, illegal, halted, bus_err;
  logic [3:0] dbg_state;
  logic [15:0] act;

  cpu_sequencer #(.OPCODE_W(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .ir_ena(ir_ena), .ir_sel(ir_sel), .pc_inc(pc_inc),
    .pc_load(pc_load), .mar_ena(mar_ena), .bus_sel(bus_sel), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .acc_ena(acc_ena), .alu_op(alu_op),
    .instr_done(instr_done), .illegal(illegal), .halted(halted),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  assign act = {ir_ena, ir_sel, pc_inc, pc_load, mar_ena, bus_sel, mem_rd,
                mem_wr, acc_ena, alu_op, instr_done, illegal, halted, bus_err};

  // Scoreboard
  logic [15:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [15:0] a, input logic [15:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: outputs got %h expected %h (state %0d)", nm, a, e, dbg_state);
  endtask

  // Driver: apply one cycle of inputs, compare at the falling edge.
  task automatic step(input logic s, input logic [4:0] op, input logic z,
                      input logic r, input logic [15:0] e, input string nm);
    logic [15:0] want;
    start = s; opcode = op; zero = z; mem_ready = r;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    check(nm, act, want);
    @(posedge clk);
    #1;
  endtask

  // Vector table
  typedef struct {
    logic        start;
    logic [4:0]  opc;
    logic        zero;
    logic        rdy;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic s, input logic [4:0] op, input logic z,
                   input logic r, input logic [15:0] e);
    vec_t t;
    t.start = s; t.opc = op; t.zero = z; t.rdy = r; t.exp = e;
    tbl.push_back(t);
  endtask

  // F0, F1 with 'waits' stalled cycles, then F1 completing. Opcode is junk
  // here since it is not looked at before DEC.
  task automatic fetch(input int waits);
    v(0, 5'($urandom_range(0, 31)), 0, 0, MAR | BS_PC);
    for (int i = 0; i < waits; i++) v(0, 5'($urandom_range(0, 31)), 0, 0, RD | BS_MEM);
    v(0, 5'($urandom_range(0, 31)), 0, 1, IRE | PCI | RD | BS_MEM);
  endtask

  // O0, O1 with 'waits' stalled cycles, then O1 completing with 'last'.
  task automatic operand(input logic [4:0] op, input int waits, input logic [15:0] last);
    v(0, op, 0, 0, MAR | BS_PC);
    for (int i = 0; i < waits; i++) v(0, op, 0, 0, RD | BS_MEM);
    v(0, op, 0, 1, last);
  endtask

  localparam logic [15:0] O1_DATA = PCI | MAR | RD | BS_MEM;
  localparam logic [15:0] O1_JUMP = PCL | RD | BS_MEM | DONE;

  initial begin
    // Idle before start
    v(0, NOP, 0, 0, '0);
    v(0, NOP, 0, 1, '0);
    v(1, NOP, 0, 0, '0);
    // ADD, zero-wait: 6 cycles
    fetch(0); v(0, ADD, 0, 0, '0); operand(ADD, 0, O1_DATA);
    v(0, ADD, 0, 1, RD | BS_MEM | ALU_ADD | ACC | DONE);
    // NOP
    fetch(0); v(0, NOP, 0, 0, DONE);
    // JZ not taken
    fetch(0); v(0, JZ, 0, 0, PCI | DONE);
    // JZ taken
    fetch(0); v(0, JZ, 1, 0, '0); operand(JZ, 0, O1_JUMP);
    // JMP with stalls in F1 and O1
    fetch(1); v(0, JMP, 0, 0, '0); operand(JMP, 2, O1_JUMP);
    // Illegal opcodes
    fetch(0); v(0, 5'b01010, 0, 0, IRE | IRS | ILL);
    fetch(0); v(0, 5'b10000, 1, 0, IRE | IRS | ILL);
    // LDA
    fetch(0); v(0, LDA, 0, 0, '0); operand(LDA, 0, O1_DATA);
    v(0, LDA, 0, 1, RD | BS_MEM | ACC | DONE);
    // SUB with stalls everywhere
    fetch(2); v(0, SUB, 0, 0, '0); operand(SUB, 1, O1_DATA);
    v(0, SUB, 0, 0, RD | BS_MEM | ALU_SUB);
    v(0, SUB, 0, 1, RD | BS_MEM | ALU_SUB | ACC | DONE);
    // STA with mem_ready 4 cycles late in EX
    fetch(0); v(0, STA, 0, 0, '0); operand(STA, 0, O1_DATA);
    for (int i = 0; i < 4; i++) v(0, STA, 0, 0, WR | BS_ACC);
    v(0, STA, 0, 1, WR | BS_ACC | DONE);
    // Ready exactly when the wait counter reaches TIMEOUT still succeeds
    fetch(TMO); v(0, NOP, 0, 0, DONE);
    // HLT, then start ignored
    fetch(0); v(0, HLT, 0, 0, DONE);
    v(0, NOP, 0, 0, HLT_O);
    v(1, NOP, 0, 1, HLT_O);
    v(1, ADD, 1, 0, HLT_O);

    // Reset
    #1;
    check("reset_outputs", act, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].start, tbl[i].opc, tbl[i].zero, tbl[i].rdy, tbl[i].exp,
           $sformatf("vec%0d", i));

    // Reset leaves HALT
    rst = 1'b0;
    #1 check("halt_rst_async", act, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, HLT, 0, 0, '0, "idle_after_halt");
    step(1, NOP, 0, 0, '0, "idle_start");
    step(0, NOP, 0, 0, MAR | BS_PC, "restart_f0");

    // Async reset in the middle of ADD's EX stall
    step(0, NOP, 0, 1, IRE | PCI | RD | BS_MEM, "rst_seq_f1");
    step(0, ADD, 0, 0, '0, "rst_seq_dec");
    step(0, ADD, 0, 0, MAR | BS_PC, "rst_seq_o0");
    step(0, ADD, 0, 1, O1_DATA, "rst_seq_o1");
    start = 1'b0; opcode = ADD; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("rst_seq_ex", act, RD | BS_MEM | ALU_ADD);
    #2 rst = 1'b0;
    #1 check("async_rst_ex", act, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, ADD, 0, 1, '0, "idle_after_rst0");
    step(0, ADD, 1, 1, '0, "idle_after_rst1");

    // Timeout in F1: TIMEOUT+1 request cycles, then sticky ERR
    step(1, NOP, 0, 0, '0, "tmo_start");
    step(0, NOP, 0, 0, MAR | BS_PC, "tmo_f0");
    for (int i = 0; i <= TMO; i++)
      step(0, NOP, 0, 0, RD | BS_MEM, $sformatf("tmo_wait%0d", i));
    step(0, NOP, 0, 1, ERR_O, "err0");
    step(1, NOP, 0, 1, ERR_O, "err1");
    step(1, ADD, 1, 0, ERR_O, "err2");

    check("scoreboard_drained", 16'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
